fp_addsub_normalize_stage: RTL and testbench
============================================

// Module: fp_addsub_normalize_stage
// PURPOSE
//  Post-addition normalizer for the FP add/sub datapath. Consumes the raw 33-bit mantissa sum, result sign and effective op
//  from the mantissa execution stage, plus the larger operand's biased exponent. Produces a left-aligned mantissa (leading one
//  at bit 31), an adjusted exponent and exception flags for the downstream rounding stage.
//  2-stage valid/ready pipeline: S1 = register + leading-zero count, S2 = shift + exponent adjust.
// PARAMETERS
//  MW    33  mantissa-sum width: bit32 carry, bit31 hidden, [30:8] fraction, [7:0] guard/round/sticky
//  EW    8   biased exponent width (single precision)
//  EMAX  255 all-ones exponent (Inf/NaN code)
// PORTS
//  clk       in   1    clock, all flops rising edge
//  rst_n     in   1    reset, asynchronous, active-low
//  InValid   in   1    input beat valid
//  InReady   out  1    stage can accept a beat
//  Sum       in   MW   mantissa sum/difference from execution stage
//  PSgn      in   1    result sign from execution stage
//  Opr       in   1    effective op (0 add, 1 sub)
//  Emax      in   EW   biased exponent of larger operand
//  OutValid  out  1    output beat valid
//  OutReady  in   1    downstream accepts beat
//  NormM     out  MW   normalized mantissa, leading one at bit 31 (bit32 always 0)
//  NormE     out  EW   adjusted biased exponent
//  Sgn       out  1    final sign
//  Zero      out  1    exact zero result
//  Ovf       out  1    exponent overflow (NormE forced to EMAX, NormM 0)
//  Unf       out  1    exponent underflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): S1/S2 valid=0; OutValid=0; NormM, NormE, Sgn, Zero, Ovf, Unf = 0. InReady=1 one cycle after release.
//  - Handshake: transfer on Valid&Ready. S2 loads when !s2_v | OutReady; S1 loads when !s1_v | s2_load; InReady = !s1_v | s2_load.
//    Latency 2 cycles, throughput 1/cycle, no bubble under back-pressure release. Data held stable while OutValid&!OutReady.
//  - InReady must not depend combinationally on InValid. Reset mid-operation discards all in-flight beats.
//  - S1: register Sum/PSgn/Opr/Emax; lz = leading zeros of Sum[31:0] (0..32, 32 = all zero) via sub-module.
//  - S2 cases, priority order:
//    a) Sum==0: Zero=1, NormM=0, NormE=0, Sgn = Opr ? 0 : PSgn (exact cancellation yields +0).
//    b) Sum[32]=1 (carry): NormM = Sum>>1 with old bit0 OR-ed into new bit0 (sticky); NormE=Emax+1;
//       if Emax+1 >= EMAX: Ovf=1, NormE=EMAX, NormM=0.
//    c) lz < Emax: NormM = Sum<<lz, NormE = Emax-lz.
//    d) lz >= Emax: Unf=1; handling per CONFIGURATION.
//  - Exponent arithmetic done in EW+1 bits, no wrap. Emax=0 inputs take case d with shift 0.
//  - Sgn = PSgn except case a. Flags mutually exclusive except Unf with Zero (flush).
// CONFIGURATION
//  Macro FPADDSUB_NORM_SUBNORM_EN:
//   defined   - case d: NormM = Sum << (Emax>0 ? Emax-1 : 0), NormE=0, Unf=1, Zero=0 (gradual underflow, subnormal out).
//   undefined - case d: flush to zero: NormM=0, NormE=0, Unf=1, Zero=1, Sgn=PSgn.
// STRUCTURE
//  Package fp_addsub_pkg: MW, EW, EMAX constants; LZW=6 lz-count width; typedef of S1 pipeline record
//  {sum, psgn, opr, emax, lz}.
//  Sub-module fp_addsub_lzc: combinational 32-bit leading-zero counter, output 0..32.
//  Top holds both pipeline registers, handshake logic and S2 shift/adjust mux.
// TESTING
//  1. Sum=33'h0_8000_0000, Emax=8'd127, Opr=0 -> 2 cycles later NormM=33'h0_8000_0000, NormE=127, all flags 0.
//  2. Sum=33'h1_0000_0001, Emax=8'd130 -> NormM=33'h0_8000_0001 (sticky kept), NormE=131; Emax=8'd254 -> Ovf=1, NormE=255, NormM=0.
//  3. Sum=33'h0_0000_8000, Emax=8'd100 -> lz=16, NormM=33'h0_8000_0000, NormE=84.
//  4. Sum=0, Opr=1, PSgn=1 -> Zero=1, Sgn=0, NormE=0.
//  5. Sum=33'h0_0010_0000 (lz=11), Emax=8'd5 -> Unf=1, NormE=0; SUBNORM_EN: NormM=33'h0_0100_0000, else NormM=0, Zero=1.
//  6. Stream 8 beats with OutReady toggling 1/0 and rst_n pulse mid-stream -> in-order output, no loss/duplication
//     pre-reset, OutValid=0 and all outputs 0 immediately on reset.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared widths and S1 pipeline record for the FP add/sub normalizer
package fp_addsub_pkg;
  localparam int MW   = 33;
  localparam int EW   = 8;
  localparam int EMAX = 255;
  localparam int LZW  = 6;
  typedef struct packed {
    logic [MW-1:0]  sum;
    logic           psgn;
    logic           opr;
    logic [EW-1:0]  emax;
    logic [LZW-1:0] lz;
  } s1_t;
endpackage

// File: rtl/fp_addsub_lzc.sv
// fp_addsub_lzc: combinational 32-bit leading-zero counter, result 0..32
module fp_addsub_lzc
  import fp_addsub_pkg::*;
(
  input  logic [31:0]    a,
  output logic [LZW-1:0] lz
);
  always_comb begin
    lz = LZW'(32);
    for (int i = 0; i < 32; i++)
      if (a[i]) lz = LZW'(31 - i);
  end
endmodule

// File: rtl/fp_addsub_normalize_stage.sv
// fp_addsub_normalize_stage: 2-stage post-add normalizer (S1 register+lzc, S2 shift+exponent adjust)
// FPADDSUB_NORM_SUBNORM_EN selects gradual underflow instead of flush-to-zero.
module fp_addsub_normalize_stage
  import fp_addsub_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [MW-1:0] Sum,
  input  logic          PSgn,
  input  logic          Opr,
  input  logic [EW-1:0] Emax,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [MW-1:0] NormM,
  output logic [EW-1:0] NormE,
  output logic          Sgn,
  output logic          Zero,
  output logic          Ovf,
  output logic          Unf
);
  logic           rdy, s1_v, s1_load, s2_load, in_fire, lz_lt;
  s1_t            s1;
  logic [LZW-1:0] lz;
  logic [EW:0]    e_inc;
  logic [MW-1:0]  nm;
  logic [EW-1:0]  ne;
  logic           nsg, nz, no, nu;
`ifdef FPADDSUB_NORM_SUBNORM_EN
  logic [EW-1:0]  sub_sh;
`endif
  fp_addsub_lzc u_lzc (.a(Sum[MW-2:0]), .lz(lz));
  assign s2_load = !OutValid | OutReady;
  assign s1_load = !s1_v | s2_load;
  assign InReady = rdy & s1_load;
  assign in_fire = InValid & InReady;
  assign e_inc   = {1'b0, s1.emax} + (EW+1)'(1);
  assign lz_lt   = {{(EW-LZW){1'b0}}, s1.lz} < s1.emax;
`ifdef FPADDSUB_NORM_SUBNORM_EN
  assign sub_sh  = (s1.emax != '0) ? s1.emax - EW'(1) : '0;
`endif
  always_comb begin
    nm  = '0;
    ne  = '0;
    nsg = s1.psgn;
    nz  = 1'b0;
    no  = 1'b0;
    nu  = 1'b0;
    if (s1.sum == '0) begin
      nz  = 1'b1;
      nsg = s1.opr ? 1'b0 : s1.psgn;
    end else if (s1.sum[MW-1]) begin
      if (e_inc >= (EW+1)'(EMAX)) begin
        no = 1'b1;
        ne = EW'(EMAX);
      end else begin
        nm = {1'b0, s1.sum[MW-1:2], s1.sum[1] | s1.sum[0]};
        ne = e_inc[EW-1:0];
      end
    end else if (lz_lt) begin
      nm = s1.sum << s1.lz;
      ne = s1.emax - EW'(s1.lz);
    end else begin
      nu = 1'b1;
`ifdef FPADDSUB_NORM_SUBNORM_EN
      nm = s1.sum << sub_sh;
`else
      nz = 1'b1;
`endif
    end
  end
  // rdy holds InReady low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy  <= 1'b0;
      s1_v <= 1'b0;
      s1   <= '0;
    end else begin
      rdy <= 1'b1;
      if (s1_load) begin
        s1_v <= in_fire;
        if (in_fire) s1 <= '{sum: Sum, psgn: PSgn, opr: Opr, emax: Emax, lz: lz};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid <= 1'b0;
      NormM    <= '0;
      NormE    <= '0;
      Sgn      <= 1'b0;
      Zero     <= 1'b0;
      Ovf      <= 1'b0;
      Unf      <= 1'b0;
    end else if (s2_load) begin
      OutValid <= s1_v;
      if (s1_v) begin
        NormM <= nm;
        NormE <= ne;
        Sgn   <= nsg;
        Zero  <= nz;
        Ovf   <= no;
        Unf   <= nu;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_normalize_stage.sv
// tb_fp_addsub_normalize_stage: randomized scoreboard bench with arithmetic reference model
module tb_fp_addsub_normalize_stage;
  logic        clk = 0, rst_n = 0, InValid = 0, OutReady = 0, PSgn = 0, Opr = 0;
  logic [32:0] Sum = '0;
  logic [7:0]  Emax = '0;
  logic        InReady, OutValid, Sgn, Zero, Ovf, Unf;
  logic [32:0] NormM;
  logic [7:0]  NormE;
  typedef struct {
    logic [32:0] m;
    logic [7:0]  e;
    logic        sg, z, o, u;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0, mode = 0;
  logic        hold_pend = 0;
  logic [46:0] hold_val;

  fp_addsub_normalize_stage dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .Sum(Sum), .PSgn(PSgn),
    .Opr(Opr), .Emax(Emax), .OutValid(OutValid), .OutReady(OutReady), .NormM(NormM),
    .NormE(NormE), .Sgn(Sgn), .Zero(Zero), .Ovf(Ovf), .Unf(Unf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [32:0] s, logic ps, logic op, logic [7:0] em);
    exp_t   r;
    longint v = longint'(s);
    int     e = int'(em);
    int     lz = 0;
    r.m = '0; r.e = '0; r.sg = ps; r.z = 0; r.o = 0; r.u = 0;
    if (v == 0) begin
      r.z  = 1;
      r.sg = op ? 1'b0 : ps;
    end else if (v >= 64'h1_0000_0000) begin
      if (e + 1 >= 255) begin
        r.o = 1;
        r.e = 8'd255;
      end else begin
        r.m = 33'((v / 2) | (v % 2));
        r.e = 8'(e + 1);
      end
    end else begin
      while (v < 64'h8000_0000) begin
        v = v * 2;
        lz++;
      end
      if (lz < e) begin
        r.m = 33'(v);
        r.e = 8'(e - lz);
      end else begin
        r.u = 1;
`ifdef FPADDSUB_NORM_SUBNORM_EN
        r.m = 33'(longint'(s) * (longint'(1) << (e > 0 ? e - 1 : 0)));
`else
        r.z = 1;
`endif
      end
    end
    return r;
  endfunction

  task automatic send(logic [32:0] s, logic ps, logic op, logic [7:0] em);
    int n = 0;
    @(negedge clk);
    Sum = s; PSgn = ps; Opr = op; Emax = em; InValid = 1;
    #1;
    while (!InReady && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL accept_timeout InReady=%b required 1", InReady);
    end else begin
      q.push_back(model(s, ps, op, em));
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    InValid = 0;
  endtask

  task automatic send_rand();
    logic [63:0] r = {$urandom(), $urandom()};
    logic [32:0] s;
    logic [7:0]  em;
    int          k = $urandom_range(0, 40);
    int          sel = $urandom_range(0, 3);
    s = (k > 36) ? 33'h0 : (k > 33) ? {1'b1, r[31:0]} : r[32:0] >> k;
    em = (sel == 0) ? 8'($urandom_range(0, 40)) : (sel == 1) ? 8'($urandom_range(245, 255))
       : 8'($urandom_range(0, 255));
    send(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), em);
    if ($urandom_range(0, 3) == 0) idle();
  endtask

  task automatic check_reset_outputs(string nm);
    checks++;
    if ({OutValid, NormM, NormE, Sgn, Zero, Ovf, Unf} !== '0) begin
      errors++;
      $display("FAIL %s OutValid=%b NormM=%h NormE=%0d Sgn=%b Zero=%b Ovf=%b Unf=%b required all 0",
               nm, OutValid, NormM, NormE, Sgn, Zero, Ovf, Unf);
    end
  endtask

  initial forever begin
    @(negedge clk);
    OutReady = (mode == 2) ? 1'b1 : (mode == 1) ? ~OutReady : 1'($urandom_range(0, 1));
  end

  // monitor: stability under back-pressure and in-order scoreboard compare
  initial forever begin
    exp_t x;
    @(negedge clk);
    #2;
    if (!rst_n) hold_pend = 0;
    else begin
      if (hold_pend) begin
        checks++;
        if (!OutValid || {NormM, NormE, Sgn, Zero, Ovf, Unf} !== hold_val) begin
          errors++;
          $display("FAIL hold OutValid=%b data=%h required 1 and %h", OutValid,
                   {NormM, NormE, Sgn, Zero, Ovf, Unf}, hold_val);
        end
      end
      hold_pend = OutValid & !OutReady;
      hold_val  = {NormM, NormE, Sgn, Zero, Ovf, Unf};
      if (OutValid && OutReady) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat NormM=%h NormE=%0d with no beat expected", NormM, NormE);
        end else begin
          x = q.pop_front();
          if (NormM !== x.m || NormE !== x.e || Sgn !== x.sg || Zero !== x.z || Ovf !== x.o || Unf !== x.u) begin
            errors++;
            $display("FAIL beat got m=%h e=%0d sg=%b z=%b o=%b u=%b required m=%h e=%0d sg=%b z=%b o=%b u=%b",
                     NormM, NormE, Sgn, Zero, Ovf, Unf, x.m, x.e, x.sg, x.z, x.o, x.u);
          end
        end
      end
    end
  end

  initial begin
    int n;
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset InReady=%b required 1", InReady);
    end
    mode = 2;
    send(33'h0_8000_0000, 0, 0, 8'd127);
    send(33'h1_0000_0001, 0, 0, 8'd130);
    send(33'h1_0000_0001, 1, 0, 8'd254);
    send(33'h0_0000_8000, 0, 1, 8'd100);
    send(33'h0, 1, 1, 8'd77);
    send(33'h0, 1, 0, 8'd77);
    send(33'h0_0010_0000, 1, 1, 8'd5);
    send(33'h0_0000_0001, 0, 1, 8'd0);
    send(33'h1_FFFF_FFFF, 0, 0, 8'd255);
    send(33'h0_0000_0003, 0, 1, 8'd31);
    idle();
    mode = 1;
    for (int i = 0; i < 5; i++) send_rand();
    @(negedge clk);
    InValid = 0;
    #3;
    rst_n = 0;
    q.delete();
    #1;
    check_reset_outputs("reset_mid_stream");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_midreset InReady=%b required 1", InReady);
    end
    for (int i = 0; i < 3; i++) send_rand();
    mode = 0;
    for (int i = 0; i < 300; i++) send_rand();
    idle();
    mode = 2;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
